// File: rtl/bird_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bird_input_ctrl_if
// Description : Signal bundle between the flap/gravity controller and its
//               surroundings (button, collision flag, bird position and the
//               move/en pulses that drive bird_generate).
//               master : the controller (drives move/en/playing/over)
//               slave  : the environment (drives btn/game_over/bird_y)
// Revision    : 1.0  initial release
// ============================================================================
interface bird_input_ctrl_if;
   logic        btn;        // raw flap button, asynchronous, active-high
   logic        game_over;  // collision flag, level
   logic [11:0] bird_y;     // current bird y from bird_generate
   logic        move;       // one-cycle flap pulse
   logic        en;         // one-cycle gravity pulse
   logic        playing;    // high in PLAY
   logic        over;       // high in OVER

   modport master (
      input  btn, game_over, bird_y,
      output move, en, playing, over
   );

   modport slave (
      output btn, game_over, bird_y,
      input  move, en, playing, over
   );
endinterface
`default_nettype wire

// File: rtl/bird_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bird_input_ctrl
// Description : Control stage in front of bird_generate. Synchronises and
//               debounces the flap button, turns accepted presses into
//               rate-limited single-cycle move pulses, produces the periodic
//               gravity en pulse and runs the IDLE/PLAY/OVER game FSM.
// Ports       : clk   - system clock
//               rstn  - asynchronous active-low reset
//               bus   - bird_input_ctrl_if.master
//                       in : btn, game_over, bird_y[11:0]
//                       out: move, en, playing, over (all registered)
// Revision    : 1.0  initial release
// ============================================================================
module bird_input_ctrl #(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int TICK_CYC     = 1_000_000,
   parameter int COOLDOWN_CYC = 5_000_000,
   parameter int FLAP_STEP    = 70
) (
   input  logic              clk,
   input  logic              rstn,
   bird_input_ctrl_if.master bus
);

   localparam int c_db_w   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int c_tick_w = (TICK_CYC     > 1) ? $clog2(TICK_CYC)     : 1;
   localparam int c_cd_w   = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;

   localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_CYC - 1);
   localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_CYC - 1);
   localparam logic [c_cd_w-1:0]   c_cd_last   = c_cd_w'(COOLDOWN_CYC - 1);
   localparam logic [11:0]         c_flap_step = 12'(FLAP_STEP);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                btn_meta_q, btn_meta_d;
   logic                btn_s_q, btn_s_d;
   logic                btn_db_q, btn_db_d;
   logic                btn_db_prev_q, btn_db_prev_d;
   logic [c_db_w-1:0]   db_cnt_q, db_cnt_d;
   logic [c_cd_w-1:0]   cd_cnt_q, cd_cnt_d;
   logic [c_tick_w-1:0] tick_cnt_q, tick_cnt_d;
   logic                move_q, move_d;
   logic                en_q, en_d;
   logic                pend_q, pend_d;
   logic                playing_q, playing_d;
   logic                over_q, over_d;

   logic                w_press;
   logic                w_flap_ok;
   logic                w_tick_tc;

   // Press event: rising edge of the debounced level; releases are ignored.
   assign w_press   = btn_db_q & ~btn_db_prev_q;
   // A flap is only honoured outside the cooldown window and when the upward
   // step cannot wrap the bird past the top of the screen.
   assign w_flap_ok = w_press && (cd_cnt_q == '0) && (bus.bird_y >= c_flap_step);
   assign w_tick_tc = (state_q == S_PLAY) && (tick_cnt_q == c_tick_last);

   always_comb begin
      btn_meta_d    = bus.btn;
      btn_s_d       = btn_meta_q;
      btn_db_prev_d = btn_db_q;

      // Debounce: the counter only runs while the synchronised input differs
      // from the accepted level, so any bounce back restarts the window.
      btn_db_d = btn_db_q;
      db_cnt_d = '0;
      if (btn_s_q != btn_db_q) begin
         if (db_cnt_q == c_db_last) begin
            btn_db_d = btn_s_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end

      // Game FSM; game_over outranks a same-cycle press.
      state_d = state_q;
      move_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_press) begin
               state_d = S_PLAY;
               move_d  = w_flap_ok;
            end
         end
         S_PLAY: begin
            if (bus.game_over) begin
               state_d = S_OVER;
            end else begin
               move_d = w_flap_ok;
            end
         end
         S_OVER:  state_d = S_OVER;
         default: state_d = S_IDLE;
      endcase

      // Cooldown: saturating down-counter reloaded by each issued move.
      cd_cnt_d = cd_cnt_q;
      if (move_d) begin
         cd_cnt_d = c_cd_last;
      end else if (cd_cnt_q != '0) begin
         cd_cnt_d = cd_cnt_q - 1'b1;
      end

      // Gravity tick: counts only while staying in PLAY, so the first tick
      // lands TICK_CYC cycles after playing rises.
      tick_cnt_d = '0;
      if ((state_q == S_PLAY) && (state_d == S_PLAY)) begin
         tick_cnt_d = w_tick_tc ? '0 : tick_cnt_q + 1'b1;
      end

      // A tick that coincides with a move is parked in pend and released on
      // the next non-move cycle; the tick counter phase is unaffected.
      en_d   = 1'b0;
      pend_d = 1'b0;
      if (state_d == S_PLAY) begin
         if (move_d) begin
            pend_d = w_tick_tc | pend_q;
         end else begin
            en_d = w_tick_tc | pend_q;
         end
      end

      playing_d = (state_d == S_PLAY);
      over_d    = (state_d == S_OVER);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         btn_meta_q    <= 1'b0;
         btn_s_q       <= 1'b0;
         btn_db_q      <= 1'b0;
         btn_db_prev_q <= 1'b0;
         db_cnt_q      <= '0;
         cd_cnt_q      <= '0;
         tick_cnt_q    <= '0;
         move_q        <= 1'b0;
         en_q          <= 1'b0;
         pend_q        <= 1'b0;
         playing_q     <= 1'b0;
         over_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         btn_meta_q    <= btn_meta_d;
         btn_s_q       <= btn_s_d;
         btn_db_q      <= btn_db_d;
         btn_db_prev_q <= btn_db_prev_d;
         db_cnt_q      <= db_cnt_d;
         cd_cnt_q      <= cd_cnt_d;
         tick_cnt_q    <= tick_cnt_d;
         move_q        <= move_d;
         en_q          <= en_d;
         pend_q        <= pend_d;
         playing_q     <= playing_d;
         over_q        <= over_d;
      end
   end

   assign bus.move    = move_q;
   assign bus.en      = en_q;
   assign bus.playing = playing_q;
   assign bus.over    = over_q;

endmodule
`default_nettype wire
